// File: rtl/romarb_if.sv
// Mapper-side PRG/CHR fetch ports and external ROM port of the shared-ROM arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface romarb_if #(
    parameter int EXTW = 22
);
    logic [20:0]     promaddr;
    logic            promreq;
    logic [7:0]      promdata;
    logic            promack;
    logic [20:0]     cromaddr;
    logic            cromreq;
    logic [7:0]      cromdata;
    logic            cromack;
    logic [EXTW-1:0] extaddr;
    logic            extreq;
    logic [7:0]      extrdata;
    logic            extack;

    modport slave (
        input  promaddr, promreq, cromaddr, cromreq, extrdata, extack,
        output promdata, promack, cromdata, cromack, extaddr, extreq
    );

    modport master (
        output promaddr, promreq, cromaddr, cromreq, extrdata, extack,
        input  promdata, promack, cromdata, cromack, extaddr, extreq
    );
endinterface

// File: rtl/romarb.sv
// Serialises PRG and CHR ROM fetches onto one req/ack external memory port.
// Define ROMARB_RR_EN for round-robin tie breaking; otherwise CHR wins every tie.
module romarb #(
    parameter int EXTW = 22
) (
    input  logic     clk,
    input  logic     reset,
    romarb_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_PRG = 2'd1,
        BUSY_CHR = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        prq0_q, crq0_q;
    logic        ppend_q, ppend_d;
    logic        cpend_q, cpend_d;
    logic [21:0] extaddr_q, extaddr_d;
    logic        extreq_q, extreq_d;
    logic [7:0]  pdata_q, pdata_d;
    logic [7:0]  cdata_q, cdata_d;
    logic        pack_q, pack_d;
    logic        cack_q, cack_d;
`ifdef ROMARB_RR_EN
    logic        last_chr_q, last_chr_d;
`endif

    logic pnew, cnew, pcand, ccand;
    logic grant_p, grant_c;

    assign pnew  = bus.promreq & ~prq0_q;
    assign cnew  = bus.cromreq & ~crq0_q;
    assign pcand = ppend_q | pnew;
    assign ccand = cpend_q | cnew;

    always_comb begin
        grant_p = 1'b0;
        grant_c = 1'b0;
        if (state_q == IDLE) begin
            if (pcand && ccand) begin
`ifdef ROMARB_RR_EN
                if (last_chr_q) grant_p = 1'b1;
                else            grant_c = 1'b1;
`else
                grant_c = 1'b1;
`endif
            end else if (pcand) begin
                grant_p = 1'b1;
            end else if (ccand) begin
                grant_c = 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_p)      state_d = BUSY_PRG;
                else if (grant_c) state_d = BUSY_CHR;
            end
            BUSY_PRG, BUSY_CHR: begin
                if (bus.extack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values; pend clears on grant so a re-request
    // during the port's own service is queued rather than lost.
    always_comb begin
        ppend_d   = (ppend_q | pnew) & ~grant_p;
        cpend_d   = (cpend_q | cnew) & ~grant_c;
        extaddr_d = extaddr_q;
        extreq_d  = extreq_q;
        pdata_d   = pdata_q;
        cdata_d   = cdata_q;
        pack_d    = 1'b0;
        cack_d    = 1'b0;
`ifdef ROMARB_RR_EN
        last_chr_d = last_chr_q;
        if (grant_c)      last_chr_d = 1'b1;
        else if (grant_p) last_chr_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (grant_p) begin
                    extreq_d  = 1'b1;
                    extaddr_d = {1'b0, bus.promaddr};
                end else if (grant_c) begin
                    extreq_d  = 1'b1;
                    extaddr_d = {1'b1, bus.cromaddr};
                end
            end
            BUSY_PRG: begin
                if (bus.extack) begin
                    pdata_d  = bus.extrdata;
                    pack_d   = 1'b1;
                    extreq_d = 1'b0;
                end
            end
            BUSY_CHR: begin
                if (bus.extack) begin
                    cdata_d  = bus.extrdata;
                    cack_d   = 1'b1;
                    extreq_d = 1'b0;
                end
            end
            default: extreq_d = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            prq0_q     <= 1'b0;
            crq0_q     <= 1'b0;
            ppend_q    <= 1'b0;
            cpend_q    <= 1'b0;
            extaddr_q  <= '0;
            extreq_q   <= 1'b0;
            pdata_q    <= '0;
            cdata_q    <= '0;
            pack_q     <= 1'b0;
            cack_q     <= 1'b0;
`ifdef ROMARB_RR_EN
            last_chr_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            prq0_q     <= bus.promreq;
            crq0_q     <= bus.cromreq;
            ppend_q    <= ppend_d;
            cpend_q    <= cpend_d;
            extaddr_q  <= extaddr_d;
            extreq_q   <= extreq_d;
            pdata_q    <= pdata_d;
            cdata_q    <= cdata_d;
            pack_q     <= pack_d;
            cack_q     <= cack_d;
`ifdef ROMARB_RR_EN
            last_chr_q <= last_chr_d;
`endif
        end
    end

    assign bus.extreq   = extreq_q;
    assign bus.promdata = pdata_q;
    assign bus.cromdata = cdata_q;
    assign bus.promack  = pack_q;
    assign bus.cromack  = cack_q;

    generate
        if (EXTW > 22) begin : g_pad
            assign bus.extaddr = {{(EXTW-22){1'b0}}, extaddr_q};
        end else begin : g_nopad
            assign bus.extaddr = extaddr_q[EXTW-1:0];
        end
    endgenerate
endmodule

// File: tb/tb_romarb.sv
// Self-checking bench for romarb: directed scenarios plus a randomized mapper/ROM
// stress run checked against a transaction-level model of the arbiter.
module tb_romarb;
    localparam int EXTW = 22;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    romarb_if #(.EXTW(EXTW)) bus();
    romarb #(.EXTW(EXTW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    bit         resp_en    = 1'b1;
    bit         resp_rand  = 1'b0;
    int         resp_lat   = 1;
    bit         force_en   = 1'b0;
    logic [7:0] force_data = 8'h00;

    int mon_viol = 0;
    bit last_chr = 1'b1;  // model: port that completed most recently

    function automatic logic [7:0] mem_f(input logic chr, input logic [20:0] a);
        return a[7:0] ^ a[15:8] ^ {3'b000, a[20:16]} ^ (chr ? 8'h5A : 8'hC3);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
        if (bus.promack) begin
            last_chr = 1'b0;
            $display("[TB] t=%0t prg ack data=%02h", $time, bus.promdata);
        end
        if (bus.cromack) begin
            last_chr = 1'b1;
            $display("[TB] t=%0t chr ack data=%02h", $time, bus.cromdata);
        end
    endtask

    // External memory model: acks after a programmable number of cycles of extreq.
    initial begin : responder
        int wcnt;
        int cur_lat;
        wcnt = 0;
        cur_lat = 1;
        bus.extack = 1'b0;
        bus.extrdata = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            if (!reset || !resp_en) begin
                wcnt = 0;
            end else if (bus.extack) begin
                bus.extack = 1'b0;
                wcnt = 0;
            end else if (bus.extreq) begin
                if (wcnt == 0) cur_lat = resp_rand ? int'($urandom_range(1, 4)) : resp_lat;
                wcnt++;
                if (wcnt >= cur_lat) begin
                    bus.extack = 1'b1;
                    bus.extrdata = force_en ? force_data : mem_f(bus.extaddr[21], bus.extaddr[20:0]);
                    wcnt = 0;
                end
            end
        end
    end

    // Protocol invariants: one-cycle acks, never both, extaddr stable under extreq.
    initial begin : monitor
        logic pa, ca, pr;
        logic [21:0] pad;
        pa = 0; ca = 0; pr = 0; pad = '0;
        forever begin
            @(posedge clk);
            #3;
            if (bus.promack && bus.cromack) mon_viol++;
            if ((bus.promack && pa) || (bus.cromack && ca)) mon_viol++;
            if (bus.extreq && pr && bus.extaddr[21:0] !== pad) mon_viol++;
            pa = bus.promack;
            ca = bus.cromack;
            pr = bus.extreq;
            pad = bus.extaddr[21:0];
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic set_req(input int p, input bit v, input logic [20:0] a);
        if (p == 1) begin
            bus.cromaddr = a;
            bus.cromreq  = v;
        end else begin
            bus.promaddr = a;
            bus.promreq  = v;
        end
    endtask

    // Issues one request and waits for its ack; returns observations only.
    task automatic xact(input int p, input logic [20:0] a, input int budget,
                        output int ncyc, output bit got,
                        output logic [21:0] first_addr, output bit req_seen);
        set_req(p, 1'b1, a);
        ncyc = 0;
        got = 1'b0;
        first_addr = '0;
        req_seen = 1'b0;
        while (!got && ncyc < budget) begin
            tick();
            ncyc++;
            if (ncyc == 1) begin
                req_seen = bus.extreq;
                first_addr = bus.extaddr[21:0];
            end
            if ((p == 1) ? bus.cromack : bus.promack) got = 1'b1;
        end
        set_req(p, 1'b0, a);
    endtask

    task automatic test_reset;
        bus.promreq = 0; bus.cromreq = 0; bus.promaddr = '0; bus.cromaddr = '0;
        reset = 1'b0;
        repeat (3) tick();
        tests++; if (bus.extreq !== 1'b0) begin fails++; $display("[TB] FAIL reset_extreq got=%b exp=0", bus.extreq); end
        tests++; if (bus.extaddr !== '0) begin fails++; $display("[TB] FAIL reset_extaddr got=%h exp=0", bus.extaddr); end
        tests++; if ({bus.promack, bus.cromack} !== 2'b00) begin fails++; $display("[TB] FAIL reset_acks got=%b exp=00", {bus.promack, bus.cromack}); end
        tests++; if ({bus.promdata, bus.cromdata} !== 16'h0000) begin fails++; $display("[TB] FAIL reset_data got=%h exp=0000", {bus.promdata, bus.cromdata}); end
        reset = 1'b1;
        last_chr = 1'b1;
        repeat (2) tick();
        tests++; if (bus.extreq !== 1'b0) begin fails++; $display("[TB] FAIL reset_idle got=%b exp=0", bus.extreq); end
    endtask

    task automatic test_prg_single;
        int n; bit got; logic [21:0] fa; bit rs;
        force_en = 1; force_data = 8'hA5; resp_rand = 0; resp_lat = 3;
        xact(0, 21'h01234, 20, n, got, fa, rs);
        tests++; if (!rs || fa !== 22'h001234) begin fails++; $display("[TB] FAIL prg_grant got req=%b addr=%h exp req=1 addr=001234", rs, fa); end
        tests++; if (!got || n != 4) begin fails++; $display("[TB] FAIL prg_latency got ack=%b cycles=%0d exp 4", got, n); end
        tests++; if (bus.promdata !== 8'hA5) begin fails++; $display("[TB] FAIL prg_data got=%h exp=a5", bus.promdata); end
        tests++; if (bus.extreq !== 1'b0) begin fails++; $display("[TB] FAIL prg_extreq_drop got=%b exp=0", bus.extreq); end
        tick();
        tests++; if (bus.promack !== 1'b0) begin fails++; $display("[TB] FAIL prg_ack_width got=%b exp=0", bus.promack); end
        force_en = 0;
    endtask

    task automatic test_chr_single;
        int n; bit got; logic [21:0] fa; bit rs;
        force_en = 1; force_data = 8'h3C; resp_rand = 0; resp_lat = 2;
        xact(1, 21'h00ABC, 20, n, got, fa, rs);
        tests++; if (!rs || fa !== 22'h200ABC) begin fails++; $display("[TB] FAIL chr_grant got req=%b addr=%h exp req=1 addr=200abc", rs, fa); end
        tests++; if (!got || n != 3) begin fails++; $display("[TB] FAIL chr_latency got ack=%b cycles=%0d exp 3", got, n); end
        tests++; if (bus.cromdata !== 8'h3C) begin fails++; $display("[TB] FAIL chr_data got=%h exp=3c", bus.cromdata); end
        tests++; if (bus.promdata !== 8'hA5) begin fails++; $display("[TB] FAIL chr_prgdata_hold got=%h exp=a5", bus.promdata); end
        tick();
        tests++; if (bus.cromack !== 1'b0) begin fails++; $display("[TB] FAIL chr_ack_width got=%b exp=0", bus.cromack); end
        force_en = 0;
    endtask

    task automatic test_mid_reset;
        int pack_cnt, req_cnt;
        resp_en = 0;
        bus.extack = 1'b0;
        set_req(0, 1'b1, 21'h1F00F);
        tick();
        tests++; if (bus.extreq !== 1'b1) begin fails++; $display("[TB] FAIL mrst_busy got=%b exp=1", bus.extreq); end
        tick();
        reset = 1'b0;
        #1;
        tests++; if (bus.extreq !== 1'b0 || bus.extaddr !== '0) begin fails++; $display("[TB] FAIL mrst_async got req=%b addr=%h exp 0/0", bus.extreq, bus.extaddr); end
        set_req(0, 1'b0, 21'h1F00F);
        tick();
        reset = 1'b1;
        last_chr = 1'b1;
        pack_cnt = 0;
        req_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            bus.extack = 1'b1;
            bus.extrdata = 8'hEE;
            tick();
            pack_cnt += int'(bus.promack);
            req_cnt += int'(bus.extreq);
            bus.extack = 1'b0;
            tick();
            pack_cnt += int'(bus.promack);
            req_cnt += int'(bus.extreq);
        end
        tests++; if (pack_cnt != 0) begin fails++; $display("[TB] FAIL mrst_stale_ack got promack_cycles=%0d exp 0", pack_cnt); end
        tests++; if (req_cnt != 0) begin fails++; $display("[TB] FAIL mrst_idle got extreq_cycles=%0d exp 0", req_cnt); end
        resp_en = 1;
    endtask

    task automatic test_tie(input string tag);
        bit first_chr;
        logic [20:0] pa, ca, fa, sa;
        int n;
        bit got;
`ifdef ROMARB_RR_EN
        first_chr = ~last_chr;
`else
        first_chr = 1'b1;
`endif
        resp_rand = 0; resp_lat = 2; force_en = 0;
        pa = 21'($urandom());
        ca = 21'($urandom());
        fa = first_chr ? ca : pa;
        sa = first_chr ? pa : ca;
        set_req(0, 1'b1, pa);
        set_req(1, 1'b1, ca);
        tick();
        tests++; if (bus.extreq !== 1'b1 || bus.extaddr[21:0] !== {first_chr, fa}) begin
            fails++; $display("[TB] FAIL %s_first got req=%b addr=%h exp req=1 addr=%h", tag, bus.extreq, bus.extaddr, {first_chr, fa}); end
        n = 0; got = 0;
        while (!got && n < 20) begin
            if (first_chr ? bus.cromack : bus.promack) got = 1;
            else begin tick(); n++; end
        end
        set_req(first_chr ? 1 : 0, 1'b0, fa);
        tests++; if (!got || (first_chr ? bus.cromdata : bus.promdata) !== mem_f(first_chr, fa) || bus.extreq !== 1'b0) begin
            fails++; $display("[TB] FAIL %s_first_done got ack=%b pdata=%h cdata=%h extreq=%b exp data=%h extreq=0", tag, got, bus.promdata, bus.cromdata, bus.extreq, mem_f(first_chr, fa)); end
        tick();
        tests++; if (bus.extreq !== 1'b1 || bus.extaddr[21:0] !== {~first_chr, sa}) begin
            fails++; $display("[TB] FAIL %s_second got req=%b addr=%h exp req=1 addr=%h", tag, bus.extreq, bus.extaddr, {~first_chr, sa}); end
        n = 0; got = 0;
        while (!got && n < 20) begin
            if (first_chr ? bus.promack : bus.cromack) got = 1;
            else begin tick(); n++; end
        end
        set_req(first_chr ? 0 : 1, 1'b0, sa);
        tests++; if (!got || (first_chr ? bus.promdata : bus.cromdata) !== mem_f(~first_chr, sa)) begin
            fails++; $display("[TB] FAIL %s_second_done got ack=%b pdata=%h cdata=%h exp data=%h", tag, got, bus.promdata, bus.cromdata, mem_f(~first_chr, sa)); end
        tick();
    endtask

    task automatic test_early_drop;
        int acks, rises;
        bit prev;
        logic [7:0] d;
        logic [20:0] a;
        resp_rand = 0; resp_lat = 3; force_en = 0;
        a = 21'h0F0F3;
        set_req(0, 1'b1, a);
        tick();
        tick();
        set_req(0, 1'b0, a);
        acks = 0; rises = 0; prev = 1'b1; d = 8'h00;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.promack) begin acks++; d = bus.promdata; end
            if (bus.extreq && !prev) rises++;
            prev = bus.extreq;
        end
        tests++; if (acks != 1) begin fails++; $display("[TB] FAIL drop_ack_count got=%0d exp 1", acks); end
        tests++; if (d !== mem_f(1'b0, a)) begin fails++; $display("[TB] FAIL drop_data got=%h exp=%h", d, mem_f(1'b0, a)); end
        tests++; if (rises != 0) begin fails++; $display("[TB] FAIL drop_extra_xact got=%0d exp 0", rises); end
    endtask

    task automatic test_busy_req;
        logic [20:0] pa, ca;
        int n;
        bit got;
        resp_rand = 0; resp_lat = 3; force_en = 0;
        pa = 21'($urandom());
        ca = 21'($urandom());
        set_req(1, 1'b1, ca);
        tick();
        set_req(0, 1'b1, pa);
        n = 0; got = 0;
        while (!got && n < 20) begin
            tick(); n++;
            if (bus.cromack) got = 1;
        end
        set_req(1, 1'b0, ca);
        tests++; if (!got || bus.cromdata !== mem_f(1'b1, ca) || bus.extreq !== 1'b0) begin
            fails++; $display("[TB] FAIL busy_chr got ack=%b data=%h extreq=%b exp data=%h extreq=0", got, bus.cromdata, bus.extreq, mem_f(1'b1, ca)); end
        tick();
        tests++; if (bus.extreq !== 1'b1 || bus.extaddr[21:0] !== {1'b0, pa}) begin
            fails++; $display("[TB] FAIL busy_prg_grant got req=%b addr=%h exp req=1 addr=%h", bus.extreq, bus.extaddr, {1'b0, pa}); end
        n = 0; got = 0;
        while (!got && n < 20) begin
            tick(); n++;
            if (bus.promack) got = 1;
        end
        set_req(0, 1'b0, pa);
        tests++; if (!got || bus.promdata !== mem_f(1'b0, pa)) begin
            fails++; $display("[TB] FAIL busy_prg_done got ack=%b data=%h exp=%h", got, bus.promdata, mem_f(1'b0, pa)); end
        tick();
    endtask

    task automatic test_random;
        bit act[2];
        logic [20:0] ad[2];
        int age[2];
        int gap[2];
        bit prev_req;
        logic ack;
        resp_rand = 1; force_en = 0;
        for (int p = 0; p < 2; p++) begin act[p] = 0; ad[p] = '0; age[p] = 0; gap[p] = 1; end
        prev_req = 1'b0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            tick();
            if (bus.extreq && !prev_req) begin
                tests++;
                if (!act[bus.extaddr[21]] || bus.extaddr[20:0] !== ad[bus.extaddr[21]]) begin
                    fails++; $display("[TB] FAIL rnd_grant got addr=%h exp an outstanding request (prg_act=%b %h chr_act=%b %h)", bus.extaddr, act[0], ad[0], act[1], ad[1]);
                end
            end
            prev_req = bus.extreq;
            for (int p = 0; p < 2; p++) begin
                ack = (p == 1) ? bus.cromack : bus.promack;
                if (ack) begin
                    tests++;
                    if (!act[p]) begin
                        fails++; $display("[TB] FAIL rnd_spurious_ack port=%0d got ack=1 exp none", p);
                    end else if (((p == 1) ? bus.cromdata : bus.promdata) !== mem_f(p[0], ad[p])) begin
                        fails++; $display("[TB] FAIL rnd_data port=%0d got=%h exp=%h", p, (p == 1) ? bus.cromdata : bus.promdata, mem_f(p[0], ad[p]));
                    end
                    act[p] = 0;
                    set_req(p, 1'b0, ad[p]);
                    gap[p] = $urandom_range(1, 5);
                end else if (act[p]) begin
                    age[p]++;
                    if (age[p] > 20) begin
                        tests++; fails++;
                        $display("[TB] FAIL rnd_timeout port=%0d got no ack in %0d cycles exp ack", p, age[p]);
                        act[p] = 0;
                        set_req(p, 1'b0, ad[p]);
                        gap[p] = 2;
                    end
                end else if (gap[p] > 0) begin
                    gap[p]--;
                end else if (cyc < 440 && $urandom_range(0, 2) == 0) begin
                    ad[p] = 21'($urandom());
                    act[p] = 1;
                    age[p] = 0;
                    set_req(p, 1'b1, ad[p]);
                end
            end
        end
        tests++; if (act[0] || act[1]) begin fails++; $display("[TB] FAIL rnd_drain got outstanding prg=%b chr=%b exp none", act[0], act[1]); end
    endtask

    initial begin : main
        test_reset();
        test_prg_single();
        test_chr_single();
        test_mid_reset();
        test_tie("tie1");
        test_early_drop();
        test_tie("tie2");
        test_busy_req();
        test_random();
        tick();
        tests++; if (mon_viol != 0) begin fails++; $display("[TB] FAIL protocol_monitor got violations=%0d exp 0", mon_viol); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
